countdown_timer: RTL and testbench
==================================

# countdown_timer

Loadable down-counter with a run/hold/expire state machine. It is the countdown counterpart of the free-running up-counter `contador`. Software or a controlling FSM loads a start value and issues `start`. The block then decrements once per enabled cycle and raises a one-cycle `done` pulse when the count reaches zero. An optional auto-reload mode turns it into a periodic tick generator.

## Interface
- `N`, 4, counter width in bits.
- `F`, 15, reset and auto-reload value; must satisfy 0 ≤ F ≤ 2^N−1.
- `AUTO`, 0, 1 = reload `F` and keep running after expiry; 0 = stop after expiry.

- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-low (0 = reset at next rising edge).
- `load`  in  1  load `load_val` into count (IDLE only).
- `load_val`  in  N  value to load.
- `start`  in  1  begin countdown (IDLE only).
- `hold`  in  1  freeze count while RUN.
- `q`  out  N  current count, registered.
- `busy`  out  1  high while state == RUN.
- `done`  out  1  high for exactly one cycle while state == EXPIRE.

## Operation
- States:
  - IDLE: waiting for load or start.
  - RUN: counting down.
  - EXPIRE: one cycle, signals completion.
- Outputs are decoded from registered state: `busy` = (RUN), `done` = (EXPIRE).
- Reset (`rst`=0 at an edge, any state): state ← IDLE, `q` ← F, `busy`=0, `done`=0. Reset overrides all other inputs.
- IDLE:
  - `load`=1, `start`=0 → `q` ← `load_val`; stay IDLE.
  - `start`=1, `load`=0 → if `q`≠0, go to RUN with `q` unchanged; if `q`=0, go to EXPIRE.
  - `load`=1 and `start`=1 together → `q` ← `load_val`. Go to RUN if `load_val`≠0, else EXPIRE.
  - Neither asserted → hold.
- RUN:
  - `hold`=1 → `q` frozen, stay RUN.
  - `hold`=0 and `q`>1 → `q` ← `q`−1.
  - `hold`=0 and `q`=1 → `q` ← 0, go to EXPIRE.
  - `load` and `start` are ignored in RUN.
- EXPIRE: `q`=0.
  - AUTO=0 → IDLE next edge, `q` stays 0.
  - AUTO=1 → `q` ← F, RUN next edge.
  - AUTO=1 with F=0 → EXPIRE repeats every cycle (`done` stays high).
  - `hold`, `load` and `start` are ignored in EXPIRE.
- Arithmetic: unsigned N-bit. The count never goes below 0; no wrap-around is possible.

## Timing
- `start` sampled at edge t (IDLE, `q`=V≥1):
  - RUN from t; `q`=V during cycle t..t+1.
  - `q`=V−k after edge t+k.
  - `q`=0 and state EXPIRE after edge t+V; `done` high cycle t+V..t+V+1.
  - IDLE after t+V+1.
- Start-to-done latency is V cycles plus the number of RUN cycles with `hold`=1.
- `busy` spans edges t..t+V (V cycles); `busy` and `done` are never high simultaneously.
- Loaded value appears on `q` one edge after `load` is sampled.
- AUTO=1: `done` period = F+1 cycles (F RUN cycles + 1 EXPIRE cycle) when `hold`=0.

## Test plan
- Reset, N=4, F=15: hold `rst`=0 for 2 edges, other inputs random → `q`=15, `busy`=0, `done`=0. Repeat with `rst`=0 asserted mid-RUN at `q`=7 → next edge `q`=15, state IDLE.
- Load 5, then `start` at edge t → `q` = 5,4,3,2,1,0 at edges t..t+5; `done`=1 only in cycle t+5..t+6; back in IDLE with `q`=0.
- Load 6, start, assert `hold` for 3 cycles when `q`=3 → `q` stays 3 for 3 cycles; `done` arrives 9 cycles after start; `busy` stays high throughout.
- `start` with `q`=0, and `load`+`start` with `load_val`=0 → EXPIRE next edge; `done` pulses once; `busy` never 1.
- AUTO=1, F=2, `start` from `q`=2 → `q` cycles 2,1,0,2,1,0…; `done` pulses every 3 cycles; `busy` is 0 only in EXPIRE cycles.
- In RUN at `q`=4: assert `load` with `load_val`=9 and `start` → both ignored; countdown continues 3,2,1,0.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/EXPIRE control; pulses done for one cycle
// when the count reaches zero, optionally reloading F for periodic operation.
module countdown_timer #(
    parameter int N    = 4,
    parameter int F    = 15,
    parameter int AUTO = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         hold,
    output logic [N-1:0] q,
    output logic         busy,
    output logic         done
);

    localparam logic [N-1:0] F_VAL = N'(F);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    state_t       state_reg;
    logic [N-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            q_reg     <= F_VAL;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        q_reg <= load_val;
                        if (start)
                            state_reg <= (load_val != '0) ? RUN : EXPIRE;
                    end else if (start) begin
                        state_reg <= (q_reg != '0) ? RUN : EXPIRE;
                    end
                end
                RUN: begin
                    if (!hold) begin
                        // q <= 1 also covers a zero count so RUN can never wrap
                        if (q_reg <= N'(1)) begin
                            q_reg     <= '0;
                            state_reg <= EXPIRE;
                        end else begin
                            q_reg <= q_reg - N'(1);
                        end
                    end
                end
                EXPIRE: begin
                    if (AUTO != 0) begin
                        q_reg     <= F_VAL;
                        state_reg <= (F_VAL == '0) ? EXPIRE : RUN;
                    end else begin
                        q_reg     <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    q_reg     <= F_VAL;
                end
            endcase
        end
    end

    assign q    = q_reg;
    assign busy = (state_reg == RUN);
    assign done = (state_reg == EXPIRE);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a default instance (F=15, AUTO=0) and an
// auto-reload instance (F=2, AUTO=1) driven by shared stimulus.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       start = 1'b0;
    logic       hold = 1'b0;

    logic [3:0] q_m, q_a;
    logic       busy_m, busy_a, done_m, done_a;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        bit         sel;
        logic [3:0] q;
        logic       busy;
        logic       done;
        string      tag;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    countdown_timer #(.N(4), .F(15), .AUTO(0)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .hold(hold), .q(q_m), .busy(busy_m), .done(done_m)
    );

    countdown_timer #(.N(4), .F(2), .AUTO(1)) dut_auto (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .hold(hold), .q(q_a), .busy(busy_a), .done(done_a)
    );

    task automatic check_val(input string tag, input int got, input int expv);
        tests_run++;
        if (got !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge outputs, then
    // pop and compare once the edge has produced them.
    task automatic step(input bit sel, input logic r, input logic ld, input logic [3:0] lv,
                        input logic st, input logic hd, input logic [3:0] eq,
                        input logic eb, input logic ed, input string tag);
        exp_t e, g;
        logic [3:0] oq;
        logic       ob, od;
        rst = r; load = ld; load_val = lv; start = st; hold = hd;
        e.sel = sel; e.q = eq; e.busy = eb; e.done = ed; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        oq = g.sel ? q_a : q_m;
        ob = g.sel ? busy_a : busy_m;
        od = g.sel ? done_a : done_m;
        $display("[TB] %s: q=%0d busy=%0d done=%0d (exp %0d/%0d/%0d)",
                 g.tag, oq, ob, od, g.q, g.busy, g.done);
        check_val({g.tag, ".q"}, int'(oq), int'(g.q));
        check_val({g.tag, ".busy"}, int'(ob), int'(g.busy));
        check_val({g.tag, ".done"}, int'(od), int'(g.done));
        check_val({g.tag, ".excl"}, int'(ob & od), 0);
        @(negedge clk);
    endtask

    task automatic idle_step(input logic [3:0] eq, input logic eb, input logic ed, input string tag);
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, eq, eb, ed, tag);
    endtask

    initial begin
        @(negedge clk);

        // Reset with random other inputs
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                 4'd15, 1'b0, 1'b0, "reset");

        // Load 5 then count down to done
        step(1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, "load5");
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, "start5");
        for (int k = 4; k >= 1; k--)
            idle_step(4'(k), 1'b1, 1'b0, "run5");
        idle_step(4'd0, 1'b0, 1'b1, "expire5");
        idle_step(4'd0, 1'b0, 1'b0, "idle5");

        // Load 6 with a 3-cycle hold at q=3
        step(1'b0, 1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 4'd6, 1'b0, 1'b0, "load6");
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0, "start6");
        for (int k = 5; k >= 3; k--)
            idle_step(4'(k), 1'b1, 1'b0, "run6");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, "hold6");
        idle_step(4'd2, 1'b1, 1'b0, "run6b");
        idle_step(4'd1, 1'b1, 1'b0, "run6b");
        idle_step(4'd0, 1'b0, 1'b1, "expire6");
        idle_step(4'd0, 1'b0, 1'b0, "idle6");

        // Start with q=0
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, "start_q0");
        idle_step(4'd0, 1'b0, 1'b0, "idle_q0");

        // Load+start with load_val=0 from a nonzero count
        step(1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, "load3");
        step(1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, "ldst0");
        idle_step(4'd0, 1'b0, 1'b0, "idle_ldst0");

        // load/start ignored while running
        step(1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 4'd7, 1'b0, 1'b0, "load7");
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, "start7");
        for (int k = 6; k >= 4; k--)
            idle_step(4'(k), 1'b1, 1'b0, "run7");
        step(1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, "ignore_ld");
        idle_step(4'd2, 1'b1, 1'b0, "run7b");
        idle_step(4'd1, 1'b1, 1'b0, "run7b");
        idle_step(4'd0, 1'b0, 1'b1, "expire7");
        idle_step(4'd0, 1'b0, 1'b0, "idle7");

        // Reset in the middle of a run at q=7
        step(1'b0, 1'b1, 1'b1, 4'd10, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0, "load10");
        step(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd10, 1'b1, 1'b0, "start10");
        for (int k = 9; k >= 7; k--)
            idle_step(4'(k), 1'b1, 1'b0, "run10");
        step(1'b0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0, 4'd15, 1'b0, 1'b0, "midreset");
        idle_step(4'd15, 1'b0, 1'b0, "after_rst");

        // Auto-reload instance, F=2
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, "a_reset");
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, "a_start");
        for (int p = 0; p < 3; p++) begin
            step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, "a_run1");
            step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, "a_expire");
            step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, "a_reload");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
